// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared ALU (IDLE/EXEC/RESP).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to 0.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req0_ctl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  input  logic        req1_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_ctl,
  output logic        alu_lt,
  output logic        alu_ltu,
  input  logic [31:0] alu_result,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_op;
  logic        r_ctl;
  logic        r_owner;
  logic [31:0] r_result;
  logic        r_rsp0_valid;
  logic        r_rsp1_valid;

  logic        w_idle;
  logic        w_pick1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_rsp_hs;

  // Grants only exist in IDLE and never while reset is held.
  assign w_idle = rst_n && (r_state == IDLE);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic r_last;
  logic w_both;

  assign w_both  = req0_valid && req1_valid;
  assign w_pick1 = w_both && !r_last;

  // Remember who won the latest acceptance for the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_gnt0 || w_gnt1) begin
      r_last <= w_gnt1;
    end
  end
`else
  assign w_pick1 = 1'b0;
`endif

  assign w_gnt0 = w_idle && req0_valid && !w_pick1;
  assign w_gnt1 = w_idle && req1_valid &&
                  (!req0_valid || w_pick1);

  assign w_rsp_hs = r_owner ? rsp1_ready : rsp0_ready;

  // Transaction FSM with operand, result and response-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_ctl        <= 1'b0;
      r_owner      <= 1'b0;
      r_result     <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_a     <= w_gnt1 ? req1_a   : req0_a;
            r_b     <= w_gnt1 ? req1_b   : req0_b;
            r_op    <= w_gnt1 ? req1_op  : req0_op;
            r_ctl   <= w_gnt1 ? req1_ctl : req0_ctl;
            r_owner <= w_gnt1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_result     <= alu_result;
          r_rsp0_valid <= !r_owner;
          r_rsp1_valid <= r_owner;
          r_state      <= RESP;
        end
        RESP: begin
          if (w_rsp_hs) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_rsp0_valid <= 1'b0;
          r_rsp1_valid <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  assign alu_a   = r_a;
  assign alu_b   = r_b;
  assign alu_op  = r_op;
  assign alu_ctl = r_ctl;
  assign alu_lt  = $signed(r_a) < $signed(r_b);
  assign alu_ltu = r_a < r_b;

  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp_result = r_result;

endmodule
